// File: rtl/ppu_pixel_fifo.sv
// ppu_pixel_fifo: elastic RGB222 byte buffer between the ppu strobe/ack output
// and the vga_driver pixel input. Streams one byte per active (de) cycle once a
// frame boundary finds enough prefill, and outputs black otherwise. Bits [1:0]
// of every emitted byte are forced low so pixel data never looks like the
// vga_driver 2'b11 counter-reset code.
// Optional build macro: FIFO_STATS_EN adds the saturating underrun_cnt output.
module ppu_pixel_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned PREFILL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_stb,
  output logic              in_ack,
  input  logic              de,
  input  logic              vsync,
  output logic [7:0]        pix_data,
  output logic              underrun,
  output logic [ADDR_W:0]   level
`ifdef FIFO_STATS_EN
  , output logic [15:0]     underrun_cnt
`endif
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  typedef enum logic {
    S_FILL   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   level_q, level_d;
  logic               in_ack_q, in_ack_d;
  logic [7:0]         pix_data_q, pix_data_d;
  logic               underrun_q, underrun_d;
  logic               vsync_q, vsync_d;
  logic [7:0]         mem_q [DEPTH];

  logic               full, empty, frame_start;
  logic               push, pop, underrun_evt;
  logic [7:0]         head;

`ifdef FIFO_STATS_EN
  logic [15:0]        underrun_cnt_q, underrun_cnt_d;
`endif

  // Occupancy flags from the wrap-bit pointers
  always_comb begin
    full        = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    empty       = (wr_ptr_q == rd_ptr_q);
    frame_start = vsync_q && !vsync;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // Next-state: wait for a prefilled frame start, fall back on underrun
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:   if (frame_start && (level_q >= PTR_W'(PREFILL))) state_d = S_STREAM;
      S_STREAM: if (de && empty) state_d = S_FILL;
      default:  state_d = S_FILL;
    endcase
  end

  // Datapath/outputs: handshake, pop, pixel masking and sticky underrun
  always_comb begin
    push         = in_stb && !full && !in_ack_q;
    pop          = (state_q == S_STREAM) && de && !empty;
    underrun_evt = (state_q == S_STREAM) && de && empty;
    head         = mem_q[rd_ptr_q[ADDR_W-1:0]];
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    level_d      = wr_ptr_d - rd_ptr_d;
    in_ack_d     = push;
    pix_data_d   = pop ? {head[7:2], 2'b00} : 8'h00;
    underrun_d   = underrun_q | underrun_evt;
    vsync_d      = vsync;
`ifdef FIFO_STATS_EN
    underrun_cnt_d = underrun_cnt_q;
    if (underrun_evt && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_d = underrun_cnt_q + 16'd1;
`endif
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ack_q   <= 1'b0;
      pix_data_q <= 8'h00;
      underrun_q <= 1'b0;
      vsync_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ack_q   <= in_ack_d;
      pix_data_q <= pix_data_d;
      underrun_q <= underrun_d;
      vsync_q    <= vsync_d;
    end
  end

`ifdef FIFO_STATS_EN
  // Saturating underrun event counter
  always_ff @(posedge clk) begin
    if (rst) underrun_cnt_q <= 16'h0000;
    else     underrun_cnt_q <= underrun_cnt_d;
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

  // Storage array; contents survive reset and underrun, only pointers matter
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data;
  end

  assign in_ack   = in_ack_q;
  assign pix_data = pix_data_q;
  assign underrun = underrun_q;
  assign level    = level_q;

endmodule
